// File: rtl/mac_dot_sequencer.sv
// mac_dot_sequencer: FIFO-buffered operand sequencer for an 8x8 MAC; define MAC_SEQ_ABORT_EN to add the abort input
module mac_dot_sequencer #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
`ifdef MAC_SEQ_ABORT_EN
  input  logic                     abort,
`endif
  input  logic                     start,
  input  logic [LEN_W-1:0]         vec_len,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_a,
  input  logic [7:0]               in_b,
  output logic [7:0]               mac_a,
  output logic [7:0]               mac_b,
  output logic                     mac_en,
  output logic                     mac_clr,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;
  state_t r_state, w_next;
  logic [15:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0] r_level;
  logic [LEN_W-1:0] r_cnt;
  logic [7:0] r_mac_a, r_mac_b;
  logic r_mac_en, r_mac_clr, r_done;
  logic w_abort, w_push, w_pop;
`ifdef MAC_SEQ_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif
  // level MSB is set only when the FIFO holds exactly DEPTH entries
  assign in_ready = !r_level[AW];
  assign w_push = in_valid && in_ready && !w_abort;
  assign w_pop = r_state == RUN && r_level != '0 && !w_abort;
  assign mac_a = r_mac_a;
  assign mac_b = r_mac_b;
  assign mac_en = r_mac_en;
  assign mac_clr = r_mac_clr;
  assign done = r_done;
  assign level = r_level;
  assign busy = r_state == CLEAR || r_state == RUN;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? CLEAR : IDLE;
      CLEAR:   w_next = r_cnt != '0 ? RUN : DONE;
      RUN:     w_next = w_pop && r_cnt == LEN_W'(1) ? DONE : RUN;
      default: w_next = IDLE;
    endcase
    if (w_abort) w_next = IDLE;
  end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wptr] <= {in_a, in_b};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_wptr <= '0;
      r_rptr <= '0;
      r_level <= '0;
      r_cnt <= '0;
      r_mac_a <= '0;
      r_mac_b <= '0;
      r_mac_en <= 1'b0;
      r_mac_clr <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wptr <= w_abort ? '0 : r_wptr + AW'(w_push);
      r_rptr <= w_abort ? '0 : r_rptr + AW'(w_pop);
      r_level <= w_abort ? '0 : r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
      r_cnt <= w_abort ? '0 : r_state == IDLE && start ? vec_len : r_cnt - LEN_W'(w_pop);
      if (w_pop) {r_mac_a, r_mac_b} <= r_mem[r_rptr];
      r_mac_en <= w_pop;
      r_mac_clr <= w_next == CLEAR;
      r_done <= r_state == DONE && !w_abort;
    end
endmodule
